// File: rtl/mic_fifo_if.sv
// Sample-in / SPI-out handshake bundle for mic_sample_fifo.
// The master side is the producer plus SPI slave; the slave side is the FIFO.
interface mic_fifo_if #(
    parameter int DEPTH = 16
);
    logic                     sample_valid;
    logic signed [23:0]       sample_data;
    logic [2:0]               sample_chan;
    logic                     ssel;
    logic                     data_needed;
    logic                     clr_flags;
    logic [23:0]              data_to_send;
    logic [$clog2(DEPTH):0]   level;
    logic                     overflow;
    logic                     underrun;

    modport master (
        output sample_valid, sample_data, sample_chan, ssel, data_needed, clr_flags,
        input  data_to_send, level, overflow, underrun
    );

    modport slave (
        input  sample_valid, sample_data, sample_chan, ssel, data_needed, clr_flags,
        output data_to_send, level, overflow, underrun
    );
endinterface

// File: rtl/mic_sample_fifo.sv
// Microphone sample FIFO feeding an SPI slave load port; pops on the first SCK edge of a word.
// Optional MIC_FIFO_CHAN_TAG_EN stores the channel index and presents {chan, sample[23:3]}.
module mic_sample_fifo #(
    parameter int DEPTH = 16
) (
    input logic       clk,
    input logic       rst_n,
    mic_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [23:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          dn_q;
    logic          ovf;
    logic          unr;
    logic [23:0]   new_entry;

    logic full;
    logic empty;
    logic pop_evt;
    logic do_pop;
    logic do_push;
    logic set_ovf;
    logic set_unr;

`ifdef MIC_FIFO_CHAN_TAG_EN
    logic [2:0] data_lsb_unused;
    assign data_lsb_unused = bus.sample_data[2:0];
    assign new_entry       = {bus.sample_chan, bus.sample_data[23:3]};
`else
    logic [2:0] chan_unused;
    assign chan_unused = bus.sample_chan;
    assign new_entry   = bus.sample_data;
`endif

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    // Load window closing with select still active marks a word being shifted out.
    assign pop_evt = dn_q & ~bus.data_needed & ~bus.ssel;
    assign do_pop  = pop_evt & ~empty;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts the sample.
    assign do_push = bus.sample_valid & (~full | do_pop);
    assign set_ovf = bus.sample_valid & ~do_push;
    assign set_unr = pop_evt & empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dn_q   <= 1'b0;
            ovf    <= 1'b0;
            unr    <= 1'b0;
        end else begin
            dn_q <= bus.data_needed;
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
            if (set_ovf) begin
                ovf <= 1'b1;
            end else if (bus.clr_flags) begin
                ovf <= 1'b0;
            end
            if (set_unr) begin
                unr <= 1'b1;
            end else if (bus.clr_flags) begin
                unr <= 1'b0;
            end
        end
    end

    assign bus.data_to_send = empty ? 24'h000000 : mem[rd_ptr];
    assign bus.level        = count;
    assign bus.overflow     = ovf;
    assign bus.underrun     = unr;
endmodule

// File: tb/tb_mic_sample_fifo.sv
// Bench for mic_sample_fifo: constant vector table plus a queue scoreboard for corner sequences.
module tb_mic_sample_fifo;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mic_fifo_if #(.DEPTH(DEPTH)) bus ();

    mic_sample_fifo #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [23:0] q[$];
    logic        m_dnq;
    logic        m_ovf;
    logic        m_unr;

    typedef struct {
        logic        sv;
        logic [23:0] data;
        logic        ssel;
        logic        dn;
        int          lvl;
        logic [23:0] dts;
    } vec_t;

    vec_t vecs[13];

    function automatic logic [23:0] exp_word(input logic [23:0] d, input logic [2:0] c);
`ifdef MIC_FIFO_CHAN_TAG_EN
        return {c, d[23:3]};
`else
        logic [2:0] c_unused;
        c_unused = c;
        return d;
`endif
    endfunction

    function automatic vec_t mk(input logic sv, input logic [23:0] data, input logic ssel,
                                input logic dn, input int lvl, input logic [23:0] dts);
        vec_t v;
        v.sv = sv; v.data = data; v.ssel = ssel; v.dn = dn; v.lvl = lvl; v.dts = dts;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic idle();
        bus.sample_valid = 1'b0;
        bus.sample_data  = '0;
        bus.sample_chan  = '0;
        bus.ssel         = 1'b1;
        bus.data_needed  = 1'b0;
        bus.clr_flags    = 1'b0;
    endtask

    // One clock: predict from the current inputs, clock, then compare against the queue model.
    task automatic cycle();
        logic pop_evt, do_pop, push_ok, set_ovf, set_unr;
        pop_evt = m_dnq && !bus.data_needed && !bus.ssel;
        do_pop  = pop_evt && (q.size() != 0);
        set_unr = pop_evt && (q.size() == 0);
        push_ok = bus.sample_valid && ((q.size() < DEPTH) || do_pop);
        set_ovf = bus.sample_valid && !push_ok;
        @(posedge clk);
        #1;
        if (do_pop) void'(q.pop_front());
        if (push_ok) q.push_back(exp_word(bus.sample_data, bus.sample_chan));
        m_dnq = bus.data_needed;
        m_ovf = set_ovf ? 1'b1 : (bus.clr_flags ? 1'b0 : m_ovf);
        m_unr = set_unr ? 1'b1 : (bus.clr_flags ? 1'b0 : m_unr);
        check("level", 32'(bus.level), q.size());
        check("data_to_send", bus.data_to_send, (q.size() != 0) ? q[0] : 24'h0);
        check("overflow", bus.overflow, m_ovf);
        check("underrun", bus.underrun, m_unr);
    endtask

    task automatic push(input logic [23:0] d, input logic [2:0] c);
        bus.sample_valid = 1'b1;
        bus.sample_data  = d;
        bus.sample_chan  = c;
        cycle();
        bus.sample_valid = 1'b0;
    endtask

    task automatic spi_word(output logic [23:0] loaded);
        bus.ssel        = 1'b0;
        bus.data_needed = 1'b1;
        repeat (4) cycle();
        loaded          = bus.data_to_send;
        bus.data_needed = 1'b0;
        cycle();
        bus.ssel        = 1'b1;
        cycle();
    endtask

    task automatic clr_pulse();
        bus.clr_flags = 1'b1;
        cycle();
        bus.clr_flags = 1'b0;
    endtask

    task automatic model_reset();
        q.delete();
        m_dnq = 1'b0;
        m_ovf = 1'b0;
        m_unr = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_level", 32'(bus.level), 0);
        check("rst_data", bus.data_to_send, 24'h0);
        check("rst_flags", {bus.overflow, bus.underrun}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [23:0] pat(input int i);
        return 24'(i * 24'h010203 + 24'h000011);
    endfunction

    initial begin
        logic [23:0] w;
        logic [23:0] a;
        logic [23:0] b;
        a = exp_word(24'h123456, 3'd0);
        b = exp_word(24'hABCDEF, 3'd0);

        vecs[0]  = mk(1'b1, 24'h123456, 1'b1, 1'b0, 1, a);
        vecs[1]  = mk(1'b1, 24'hABCDEF, 1'b1, 1'b0, 2, a);
        vecs[2]  = mk(1'b0, 24'h0, 1'b0, 1'b1, 2, a);
        vecs[3]  = mk(1'b0, 24'h0, 1'b0, 1'b1, 2, a);
        vecs[4]  = mk(1'b0, 24'h0, 1'b0, 1'b1, 2, a);
        vecs[5]  = mk(1'b0, 24'h0, 1'b0, 1'b1, 2, a);
        vecs[6]  = mk(1'b0, 24'h0, 1'b0, 1'b0, 1, b);
        vecs[7]  = mk(1'b0, 24'h0, 1'b0, 1'b1, 1, b);
        vecs[8]  = mk(1'b0, 24'h0, 1'b0, 1'b1, 1, b);
        vecs[9]  = mk(1'b0, 24'h0, 1'b0, 1'b1, 1, b);
        vecs[10] = mk(1'b0, 24'h0, 1'b0, 1'b1, 1, b);
        vecs[11] = mk(1'b0, 24'h0, 1'b0, 1'b0, 0, 24'h0);
        vecs[12] = mk(1'b0, 24'h0, 1'b1, 1'b0, 0, 24'h0);

        do_reset();

        for (int i = 0; i < 13; i++) begin
            bus.sample_valid = vecs[i].sv;
            bus.sample_data  = vecs[i].data;
            bus.ssel         = vecs[i].ssel;
            bus.data_needed  = vecs[i].dn;
            cycle();
            check($sformatf("vec%0d_level", i), 32'(bus.level), vecs[i].lvl);
            check($sformatf("vec%0d_data", i), bus.data_to_send, vecs[i].dts);
            check($sformatf("vec%0d_flags", i), {bus.overflow, bus.underrun}, 2'b00);
        end
        idle();

        // Overfill by one; clr_flags on the dropping cycle must lose to the set.
        do_reset();
        for (int i = 0; i < DEPTH; i++) push(pat(i), 3'(i));
        bus.clr_flags = 1'b1;
        push(pat(DEPTH), 3'd7);
        bus.clr_flags = 1'b0;
        check("full_level", 32'(bus.level), DEPTH);
        check("full_overflow", bus.overflow, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            spi_word(w);
            check($sformatf("drain%0d", i), w, exp_word(pat(i), 3'(i)));
        end
        check("drained_level", 32'(bus.level), 0);
        check("drained_data", bus.data_to_send, 24'h0);
        clr_pulse();
        check("ovf_cleared", bus.overflow, 1'b0);

        // Underrun on an empty FIFO.
        spi_word(w);
        check("underrun_word", w, 24'h0);
        check("underrun_flag", bus.underrun, 1'b1);
        check("underrun_level", 32'(bus.level), 0);
        clr_pulse();
        check("underrun_cleared", bus.underrun, 1'b0);

        // data_needed dropping together with ssel rising must not pop.
        push(24'h0A0A0A, 3'd1);
        push(24'h0B0B0B, 3'd2);
        push(24'h0C0C0C, 3'd3);
        bus.ssel        = 1'b0;
        bus.data_needed = 1'b1;
        cycle();
        bus.ssel        = 1'b1;
        bus.data_needed = 1'b0;
        cycle();
        check("ssel_level", 32'(bus.level), 3);
        check("ssel_head", bus.data_to_send, exp_word(24'h0A0A0A, 3'd1));
        spi_word(w);
        check("ssel_next_word", w, exp_word(24'h0A0A0A, 3'd1));

        // Simultaneous push and pop at level 0.
        do_reset();
        bus.ssel        = 1'b0;
        bus.data_needed = 1'b1;
        cycle();
        bus.data_needed = 1'b0;
        push(24'h777777, 3'd4);
        check("simul0_level", 32'(bus.level), 1);
        check("simul0_underrun", bus.underrun, 1'b1);
        check("simul0_data", bus.data_to_send, exp_word(24'h777777, 3'd4));
        bus.ssel = 1'b1;
        clr_pulse();

        // Simultaneous push and pop at level DEPTH.
        for (int i = 1; i < DEPTH; i++) push(pat(i + 40), 3'(i));
        check("pre_full_level", 32'(bus.level), DEPTH);
        bus.ssel        = 1'b0;
        bus.data_needed = 1'b1;
        cycle();
        bus.data_needed = 1'b0;
        push(24'h5A5A5A, 3'd6);
        check("simulF_level", 32'(bus.level), DEPTH);
        check("simulF_overflow", bus.overflow, 1'b0);
        bus.ssel = 1'b1;
        cycle();

        // Simultaneous push and pop at level 5.
        while (q.size() > 5) spi_word(w);
        bus.ssel        = 1'b0;
        bus.data_needed = 1'b1;
        cycle();
        bus.data_needed = 1'b0;
        push(24'hC3C3C3, 3'd0);
        check("simul5_level", 32'(bus.level), 5);
        check("simul5_flags", {bus.overflow, bus.underrun}, 2'b00);
        bus.ssel = 1'b1;
        cycle();

        // Asynchronous reset mid-cycle, released inside an SPI transaction.
        bus.ssel        = 1'b0;
        bus.data_needed = 1'b1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_level", 32'(bus.level), 0);
        check("async_data", bus.data_to_send, 24'h0);
        @(negedge clk);
        rst_n           = 1'b1;
        bus.data_needed = 1'b0;
        cycle();
        cycle();
        check("release_underrun", bus.underrun, 1'b0);
        idle();

`ifdef MIC_FIFO_CHAN_TAG_EN
        push(24'hFFFFFF, 3'd5);
        check("chan_tag", bus.data_to_send, 24'hBFFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mic_sample_fifo.md
MIC_SAMPLE_FIFO -- requirements
Module: mic_sample_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO depth in 24-bit words; SHALL be a power of two, 4..256.
REQ-002 clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 sample_valid  input  1  one-cycle strobe: sample_data/sample_chan valid this cycle.
REQ-005 sample_data  input  24  signed PCM sample from the mic decimator.
REQ-006 sample_chan  input  3  mic channel index of sample_data.
REQ-007 ssel  input  1  SPI chip select, active-low, raw pin level.
REQ-008 data_needed  input  1  level from SPI slave: high while select is active and the bit counter is 0.
REQ-009 data_to_send  output  24  word presented to the SPI slave load port.
REQ-010 level  output  $clog2(DEPTH)+1  current occupancy.
REQ-011 overflow  output  1  sticky: a sample was dropped because the FIFO was full.
REQ-012 underrun  output  1  sticky: a word was consumed while the FIFO was empty.
REQ-013 clr_flags  input  1  one-cycle strobe clearing overflow and underrun.

Function
- REQ-014 Push: sample_valid=1 and not full SHALL write the sample at the write pointer; level +1 on the next edge.
- REQ-015 Full (level==DEPTH) with sample_valid=1: the sample SHALL be discarded and overflow SHALL set; FIFO contents unchanged.
- REQ-016 data_to_send SHALL combinationally present the head word whenever level>0, and 24'h000000 when level==0.
- REQ-017 data_needed SHALL be registered once (dn_q); pop event = dn_q==1 and data_needed==0 and ssel==0, i.e. the load window closed on the first SCK edge of a word.
- REQ-018 Pop event with level>0: read pointer +1, level -1 on the same edge.
- REQ-019 Pop event with level==0: pointers unchanged, underrun SHALL set.
- REQ-020 data_needed falling because ssel went high (ssel==1 in that cycle) SHALL NOT pop; the head word is retained for the next transaction.
- REQ-021 Simultaneous push and pop, level==DEPTH: both SHALL occur; level stays DEPTH; overflow SHALL NOT set.
- REQ-022 Simultaneous push and pop, level==0: push SHALL occur, pop SHALL be ignored, underrun SHALL set; level becomes 1.
- REQ-023 Simultaneous push and pop, 0<level<DEPTH: both SHALL occur; level unchanged.
- REQ-024 Pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 with no gap.
- REQ-025 clr_flags SHALL clear both flags on the next edge; a set condition in the same cycle SHALL win (flag stays 1).
- REQ-026 Latency: a sample pushed into an empty FIFO SHALL appear on data_to_send on the next clk edge.

Reset
- REQ-027 rst_n low SHALL immediately clear pointers, level, dn_q, overflow and underrun, with data_to_send=24'h000000.
- REQ-028 Storage array contents need not be reset.
- REQ-029 Deassertion mid-SPI-transaction SHALL NOT generate a pop: dn_q is 0 out of reset.

Configuration
- REQ-030 Macro MIC_FIFO_CHAN_TAG_EN.
- REQ-031 Defined: each entry SHALL store sample_chan with the sample; data_to_send = {chan[2:0], sample[23:3]}.
- REQ-032 Undefined: entries SHALL be 24 bits; data_to_send = sample[23:0]; sample_chan is ignored.
- REQ-033 All other behaviour SHALL be identical in both builds.

Verification
- REQ-034 Reset, push 24'h123456 then 24'hABCDEF, run 2 SPI words (data_needed high 4 clk, then low, ssel low) -> data_to_send 123456 then ABCDEF; level 2->1->0; no flags.
- REQ-035 Push DEPTH+1 samples with no reads -> level==DEPTH, overflow=1; drain DEPTH words -> the first DEPTH samples in order; last sample absent.
- REQ-036 Empty FIFO, one SPI word -> data_to_send=0, underrun=1, level 0; clr_flags pulse -> underrun=0.
- REQ-037 data_needed falls with ssel raised in the same cycle, level=3 -> level stays 3, head unchanged.
- REQ-038 Push and pop in the same cycle at level 0, DEPTH and 5 -> levels 1, DEPTH and 5; only the level-0 case sets underrun.
- REQ-039 MIC_FIFO_CHAN_TAG_EN defined, push chan=5 data=24'hFFFFFF -> data_to_send=24'hBFFFFF.
